// File: rtl/count_seq_ctrl_if.sv
// Command, status and counter-control bundle between a host and count_seq_ctrl.
// The counter output is fed back through the same bundle so endpoint detection stays local.
interface count_seq_ctrl_if #(
    parameter int Nbits = 4,
    parameter int Pbits = 4
);
    logic             start;
    logic             abort;
    logic             pause;
    logic [Nbits-1:0] start_val;
    logic [Nbits-1:0] end_val;
    logic             dir;
    logic             bounce;
    logic [Pbits-1:0] passes;
    logic [Nbits-1:0] counter;
    logic             cnt_ena;
    logic             cnt_load;
    logic             cnt_updwn;
    logic [Nbits-1:0] cnt_data;
    logic             busy;
    logic             done;
    logic [Pbits-1:0] passes_left;

    modport master (
        output start, abort, pause, start_val, end_val, dir, bounce, passes, counter,
        input  cnt_ena, cnt_load, cnt_updwn, cnt_data, busy, done, passes_left
    );

    modport slave (
        input  start, abort, pause, start_val, end_val, dir, bounce, passes, counter,
        output cnt_ena, cnt_load, cnt_updwn, cnt_data, busy, done, passes_left
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// Sequencer that loads an up/down counter with a start value and runs it to an end value,
// optionally bouncing between the two endpoints for a programmed number of passes.
module count_seq_ctrl #(
    parameter int Nbits = 4,
    parameter int Pbits = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,    // asynchronous, active-low
    count_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [Nbits-1:0] r_start_val;
    logic [Nbits-1:0] r_end_val;
    logic [Nbits-1:0] r_target;
    logic             r_dir;
    logic             r_bounce;
    logic [Pbits-1:0] r_passes_left;

    logic             w_hit;
    logic             w_cnt_ena;
    logic             w_cnt_load;
    logic             w_cnt_updwn;
    logic [Nbits-1:0] w_cnt_data;
    logic             w_done;

    assign w_hit = (bus.counter == r_target);

    // Sequence state and the command fields latched when a start is accepted.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state       <= S_IDLE;
            r_start_val   <= '0;
            r_end_val     <= '0;
            r_target      <= '0;
            r_dir         <= 1'b0;
            r_bounce      <= 1'b0;
            r_passes_left <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_start_val   <= bus.start_val;
                        r_end_val     <= bus.end_val;
                        r_target      <= bus.end_val;
                        r_dir         <= bus.dir;
                        r_bounce      <= bus.bounce;
                        r_passes_left <= (bus.passes == '0) ? Pbits'(1'b1) : bus.passes;
                        r_state       <= S_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    r_state <= bus.abort ? S_IDLE : S_RUN;
                end
                S_RUN: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else if (w_hit) begin
                        // Reverse at the endpoint while passes remain; equal endpoints swap harmlessly.
                        if (r_bounce && (r_passes_left > Pbits'(1'b1))) begin
                            r_target      <= (r_target == r_end_val) ? r_start_val : r_end_val;
                            r_dir         <= ~r_dir;
                            r_passes_left <= r_passes_left - Pbits'(1'b1);
                            r_state       <= S_RUN;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Counter controls decode from state plus the live compare so the counter stops on target.
    always_comb begin
        w_cnt_ena   = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_updwn = 1'b0;
        w_cnt_data  = '0;
        w_done      = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_cnt_data = r_start_val;
                if (!bus.abort) begin
                    w_cnt_ena  = 1'b1;
                    w_cnt_load = 1'b1;
                end else begin
                    w_cnt_ena  = 1'b0;
                    w_cnt_load = 1'b0;
                end
            end
            S_RUN: begin
                w_cnt_updwn = r_dir;
                if (!bus.abort && !w_hit) begin
                    w_cnt_ena = ~bus.pause;
                end else begin
                    w_cnt_ena = 1'b0;
                end
            end
            S_DONE: begin
                w_done = ~bus.abort;
            end
            default: begin
                w_cnt_ena = 1'b0;
            end
        endcase
    end

    assign bus.cnt_ena     = w_cnt_ena;
    assign bus.cnt_load    = w_cnt_load;
    assign bus.cnt_updwn   = w_cnt_updwn;
    assign bus.cnt_data    = w_cnt_data;
    assign bus.done        = w_done;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.passes_left = r_passes_left;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl with a behavioural up/down loadable counter in the loop.
module tb_count_seq_ctrl;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [3:0] r_cnt;

    count_seq_ctrl_if #(.Nbits(4), .Pbits(4)) bus ();

    count_seq_ctrl #(.Nbits(4), .Pbits(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controlled counter: Load has priority, wraps modulo 16.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               r_cnt <= 4'd0;
        else if (bus.cnt_ena) begin
            if (bus.cnt_load)   r_cnt <= bus.cnt_data;
            else if (bus.cnt_updwn) r_cnt <= r_cnt + 4'd1;
            else                r_cnt <= r_cnt - 4'd1;
        end
    end
    assign bus.counter = r_cnt;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue a start; returns one step after the sampling edge (cycle 0, LOAD).
    task automatic start_seq(input int sv, input int ev, input int d, input int b, input int p);
        bus.start_val = 4'(sv);
        bus.end_val   = 4'(ev);
        bus.dir       = 1'(d);
        bus.bounce    = 1'(b);
        bus.passes    = 4'(p);
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    // Step until idle from cycle c0, recording done pulses and busy cycles.
    task automatic run_to_idle(input int c0, output int done_cyc, output int n_done, output int busy_cyc);
        int c;
        c = c0; done_cyc = -1; n_done = 0; busy_cyc = 0;
        while (bus.busy && (c < c0 + 300)) begin
            busy_cyc++;
            if (bus.done) begin
                n_done++;
                done_cyc = c;
            end
            tick();
            c++;
        end
        chk("idle_after_run", int'(bus.busy), 0);
    endtask

    initial begin
        int dc, nd, bc, pl1, pl5, pl9, c4, c8, upd6;
        logic [3:0] exp3 [5];
        exp3 = '{4'd2, 4'd1, 4'd0, 4'd15, 4'd14};
        n_tests = 0; n_fail = 0;
        rst = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.pause = 1'b0;
        bus.start_val = 4'd0; bus.end_val = 4'd0; bus.dir = 1'b0;
        bus.bounce = 1'b0; bus.passes = 4'd0;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ena", int'(bus.cnt_ena), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_passes_left", int'(bus.passes_left), 0);
        chk("rst_data", int'(bus.cnt_data), 0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Single up pass 3 -> 9: k=6, done at cycle 8, busy 9 cycles.
        start_seq(3, 9, 1, 0, 1);
        chk("up_load", int'(bus.cnt_load), 1);
        chk("up_load_ena", int'(bus.cnt_ena), 1);
        chk("up_load_data", int'(bus.cnt_data), 3);
        tick();
        chk("up_c1_counter", int'(bus.counter), 3);
        chk("up_c1_updwn", int'(bus.cnt_updwn), 1);
        chk("up_c1_data", int'(bus.cnt_data), 0);
        run_to_idle(1, dc, nd, bc);
        chk("up_done_cycle", dc, 8);
        chk("up_done_count", nd, 1);
        chk("up_busy_cycles", bc + 1, 9);
        chk("up_final_counter", int'(bus.counter), 9);

        // Down pass 2 -> 14 wrapping through 0: k=4, done at cycle 6.
        start_seq(2, 14, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("down_trace", int'(bus.counter), int'(exp3[i]));
        end
        chk("down_hit_ena", int'(bus.cnt_ena), 0);
        chk("down_updwn", int'(bus.cnt_updwn), 0);
        run_to_idle(5, dc, nd, bc);
        chk("down_done_cycle", dc, 6);
        chk("down_final_counter", int'(bus.counter), 14);

        // Bounce 5 <-> 8, three passes: hits at 4, 8, 12; done at 13.
        start_seq(5, 8, 1, 1, 3);
        nd = 0; dc = -1; pl1 = -1; pl5 = -1; pl9 = -1; c4 = -1; c8 = -1; upd6 = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) pl1 = int'(bus.passes_left);
            if (c == 5) pl5 = int'(bus.passes_left);
            if (c == 9) pl9 = int'(bus.passes_left);
            if (c == 4) c4 = int'(bus.counter);
            if (c == 8) c8 = int'(bus.counter);
            if (c == 6) upd6 = int'(bus.cnt_updwn);
            if (bus.done) begin
                nd++;
                dc = c;
            end
        end
        chk("bounce_pl_pass1", pl1, 3);
        chk("bounce_pl_pass2", pl5, 2);
        chk("bounce_pl_pass3", pl9, 1);
        chk("bounce_top", c4, 8);
        chk("bounce_bottom", c8, 5);
        chk("bounce_down_dir", upd6, 0);
        chk("bounce_done_count", nd, 1);
        chk("bounce_done_cycle", dc, 13);
        chk("bounce_final_counter", int'(bus.counter), 8);
        chk("bounce_idle", int'(bus.busy), 0);

        // Pause cycles 3..6 on a 0 -> 6 pass: done moves from 8 to 12.
        start_seq(0, 6, 1, 0, 1);
        nd = 0; dc = -1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            bus.pause = (c >= 3 && c <= 6);
            #1;
            if (c == 5) begin
                chk("pause_frozen", int'(bus.counter), 2);
                chk("pause_ena", int'(bus.cnt_ena), 0);
                chk("pause_busy", int'(bus.busy), 1);
            end
            if (c == 7) begin
                chk("pause_resume_counter", int'(bus.counter), 2);
                chk("pause_resume_ena", int'(bus.cnt_ena), 1);
            end
            if (bus.done) begin
                nd++;
                dc = c;
            end
        end
        chk("pause_done_cycle", dc, 12);
        chk("pause_done_count", nd, 1);
        chk("pause_final_counter", int'(bus.counter), 6);

        // Abort mid-run: controls drop at once, IDLE next edge, no done, counter holds.
        start_seq(0, 15, 1, 0, 1);
        tick(); tick(); tick();
        bus.abort = 1'b1;
        #1;
        chk("abort_ena", int'(bus.cnt_ena), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_busy_same_cycle", int'(bus.busy), 1);
        tick();
        bus.abort = 1'b0;
        chk("abort_idle", int'(bus.busy), 0);
        nd = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.done) nd++;
            tick();
        end
        chk("abort_no_done", nd, 0);
        chk("abort_counter_held", int'(bus.counter), 2);

        // Start while busy is ignored, and late input changes have no effect.
        start_seq(1, 4, 1, 0, 1);
        tick(); tick();
        bus.start_val = 4'd10; bus.end_val = 4'd12; bus.dir = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        run_to_idle(3, dc, nd, bc);
        chk("busy_start_done_cycle", dc, 5);
        chk("busy_start_done_count", nd, 1);
        chk("busy_start_counter", int'(bus.counter), 4);

        // Equal endpoints, passes=0 treated as 1: done at cycle 2, busy 3 cycles.
        start_seq(7, 7, 1, 1, 0);
        chk("eq_passes_left", int'(bus.passes_left), 1);
        run_to_idle(0, dc, nd, bc);
        chk("eq_done_cycle", dc, 2);
        chk("eq_done_count", nd, 1);
        chk("eq_busy_cycles", bc, 3);
        chk("eq_counter", int'(bus.counter), 7);

        // Asynchronous reset mid-run clears outputs without waiting for an edge.
        start_seq(0, 15, 1, 0, 1);
        tick(); tick(); tick();
        chk("rst_mid_busy_before", int'(bus.busy), 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", int'(bus.busy), 0);
        chk("rst_mid_ena", int'(bus.cnt_ena), 0);
        chk("rst_mid_done", int'(bus.done), 0);
        chk("rst_mid_passes_left", int'(bus.passes_left), 0);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_release_idle", int'(bus.busy), 0);
        chk("rst_release_ena", int'(bus.cnt_ena), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
